sb_bus_arbiter: RTL and testbench
=================================

Name: sb_bus_arbiter

Overview:
- Central arbiter for the shared system bus (SoC/VP bus): fixed-priority selection among 32 master request lines.
- Issues a one-hot grant to the highest-priority requester and tracks the transaction it starts.
- Flags snoopable bursts for caches.
- A watchdog terminates hung transactions with a bus error plus end-of-transaction.
- Master index 31 (JTAG debug master) has highest priority.

Parameters:
- GRANT_TIMEOUT, 16, cycles a granted master may take to assert beginTransactionIn before the grant is withdrawn.
- BUS_TIMEOUT, 256, cycles of bus inactivity (no dataValidIn/endTransactionIn) inside a transaction before the watchdog fires.

Ports:
- clock  in  1  system bus clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- busRequests  in  32  request per master; held high until granted.
- busGrants  out  32  one-hot grant; bit i = master i.
- busErrorOut  out  1  one-cycle bus error pulse from watchdog.
- endTransactionOut  out  1  one-cycle end-of-transaction pulse from watchdog; same cycle as busErrorOut.
- busIdle  out  1  high when no transaction is granted or active.
- snoopableBurst  out  1  high for the duration of a snoopable burst.
- beginTransactionIn  in  1  OR of masters' begin strobes.
- endTransactionIn  in  1  OR of masters'/slaves' end strobes.
- dataValidIn  in  1  OR of data-valid strobes.
- addressDataIn  in  2  bus address bits [31:30]; sampled with beginTransactionIn.
- burstSizeIn  in  8  burst size (beats-1); sampled with beginTransactionIn.

Behaviour:
- Reset (async): state IDLE; busGrants=0, busErrorOut=0, endTransactionOut=0, snoopableBurst=0, busIdle=1; counters cleared.
- States: IDLE, GRANTED, BUSY.
- IDLE:
  - If any busRequests bit is set, the next edge registers busGrants = one-hot of the highest set index (31 wins over 30, …, 0 lowest) and enters GRANTED.
  - busIdle=1.
  - Grant latency: 1 cycle after request is seen.
- GRANTED:
  - busGrants held stable; busIdle=0; grant counter increments.
  - On beginTransactionIn: the next edge clears busGrants and enters BUSY.
  - Same edge captures snoopableBurst = (addressDataIn==2'b00) && (burstSizeIn!=0).
  - If GRANT_TIMEOUT cycles elapse without beginTransactionIn: clear grant, return to IDLE. No error is raised.
- BUSY:
  - busGrants=0; busIdle=0.
  - Watchdog counter cleared on dataValidIn or beginTransactionIn; otherwise increments.
  - On endTransactionIn: the next edge goes to IDLE and clears snoopableBurst.
  - If the counter reaches BUS_TIMEOUT-1 with no dataValidIn/endTransactionIn: assert busErrorOut and endTransactionOut for exactly 1 cycle, clear snoopableBurst, go to IDLE.
- Simultaneous events:
  - endTransactionIn in the same cycle as the timeout → normal end; no error.
  - Request changes while in GRANTED/BUSY are ignored until back in IDLE. Arbitration happens only in IDLE, giving at least 1 idle cycle between transactions.
- External busErrorOut/endTransactionOut are never asserted outside a watchdog event.
- Reset mid-transaction drops grants and pulses immediately (async).
- Priority is strictly fixed (no rotation); a low-index master can starve.

Test Plan:
- Request on bit 31 only → busGrants=32'h8000_0000 one cycle later, busIdle=0. Begin strobe → grant drops next cycle. Data-valid, then endTransactionIn 4 cycles later → busIdle=1, no error.
- Requests 0x8000_0001 simultaneously → grant 0x8000_0000. After its end, bit 31 released → grant 0x0000_0001 after ≥1 idle cycle.
- Grant to bit 31, beginTransactionIn never asserted → grant removed after 16 cycles, busErrorOut stays 0, busIdle=1.
- Begin with addressDataIn=2'b00, burstSizeIn=8'd7 → snoopableBurst=1 until end. Repeat with addressDataIn=2'b01 or burstSizeIn=0 → snoopableBurst=0.
- Transaction started, slave silent (no dataValid/end) → exactly at 256 idle cycles busErrorOut=1 and endTransactionOut=1 for one cycle, then IDLE. A dataValidIn at cycle 200 restarts the count.
- Assert reset during BUSY with grant pending → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/sb_bus_arbiter.sv
// Fixed-priority arbiter for the shared system bus (master 31 highest).
// Tracks the granted transaction, flags snoopable bursts and runs a bus watchdog.
module sb_bus_arbiter #(
    parameter int GRANT_TIMEOUT = 16,
    parameter int BUS_TIMEOUT   = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] busRequests,
    output logic [31:0] busGrants,
    output logic        busErrorOut,
    output logic        endTransactionOut,
    output logic        busIdle,
    output logic        snoopableBurst,
    input  logic        beginTransactionIn,
    input  logic        endTransactionIn,
    input  logic        dataValidIn,
    input  logic [1:0]  addressDataIn,
    input  logic [7:0]  burstSizeIn
);

    localparam int GW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam int BW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [GW-1:0] GRANT_LAST = GW'(GRANT_TIMEOUT - 1);
    localparam logic [BW-1:0] BUS_LAST   = BW'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_BUSY
    } state_t;

    state_t          r_state;
    logic [31:0]     r_grants;
    logic [GW-1:0]   r_grantCount;
    logic [BW-1:0]   r_watchdog;
    logic            r_snoop;
    logic            r_error;

    state_t          w_nextState;
    logic [31:0]     w_nextGrants;
    logic [GW-1:0]   w_nextGrantCount;
    logic [BW-1:0]   w_nextWatchdog;
    logic            w_nextSnoop;
    logic            w_nextError;
    logic [31:0]     w_pick;

    // Later (higher) indices overwrite earlier ones, so the highest requester wins.
    always_comb begin
        w_pick = '0;
        for (int i = 0; i < 32; i++) begin
            if (busRequests[i]) begin
                w_pick    = '0;
                w_pick[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grants     <= '0;
            r_grantCount <= '0;
            r_watchdog   <= '0;
            r_snoop      <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_grants     <= w_nextGrants;
            r_grantCount <= w_nextGrantCount;
            r_watchdog   <= w_nextWatchdog;
            r_snoop      <= w_nextSnoop;
            r_error      <= w_nextError;
        end
    end

    always_comb begin
        w_nextState      = r_state;
        w_nextGrants     = r_grants;
        w_nextGrantCount = r_grantCount;
        w_nextWatchdog   = r_watchdog;
        w_nextSnoop      = r_snoop;
        w_nextError      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_nextGrants     = '0;
                w_nextGrantCount = '0;
                w_nextWatchdog   = '0;
                if (|busRequests) begin
                    w_nextGrants = w_pick;
                    w_nextState  = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (beginTransactionIn) begin
                    w_nextGrants   = '0;
                    w_nextWatchdog = '0;
                    w_nextSnoop    = (addressDataIn == 2'b00) && (burstSizeIn != 8'd0);
                    w_nextState    = ST_BUSY;
                end else if (r_grantCount == GRANT_LAST) begin
                    // Master never started: withdraw silently, no bus error.
                    w_nextGrants = '0;
                    w_nextState  = ST_IDLE;
                end else begin
                    w_nextGrantCount = r_grantCount + 1'b1;
                end
            end
            ST_BUSY: begin
                w_nextGrants = '0;
                // A real end beats a coinciding watchdog expiry.
                if (endTransactionIn) begin
                    w_nextSnoop = 1'b0;
                    w_nextState = ST_IDLE;
                end else if (dataValidIn || beginTransactionIn) begin
                    w_nextWatchdog = '0;
                end else if (r_watchdog == BUS_LAST) begin
                    w_nextError = 1'b1;
                    w_nextSnoop = 1'b0;
                    w_nextState = ST_IDLE;
                end else begin
                    w_nextWatchdog = r_watchdog + 1'b1;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign busGrants         = r_grants;
    assign busErrorOut       = r_error;
    assign endTransactionOut = r_error;
    assign busIdle           = (r_state == ST_IDLE);
    assign snoopableBurst    = r_snoop;

endmodule

// File: tb/tb_sb_bus_arbiter.sv
// Self-checking bench for sb_bus_arbiter: vector table plus hand-written
// sequences for grant timeout, watchdog expiry and asynchronous reset.
module tb_sb_bus_arbiter;

    typedef struct {
        logic [31:0] req;
        logic        beginT;
        logic        endT;
        logic        dv;
        logic [1:0]  addr;
        logic [7:0]  burst;
        logic [31:0] expGrants;
        logic        expIdle;
        logic        expSnoop;
        logic        expErr;
        logic        expEot;
    } vec_t;

    typedef struct packed {
        logic [31:0] grants;
        logic        idle;
        logic        snoop;
        logic        err;
        logic        eot;
    } out_t;

    logic        clock;
    logic        reset;
    logic [31:0] busRequests;
    logic [31:0] busGrants;
    logic        busErrorOut;
    logic        endTransactionOut;
    logic        busIdle;
    logic        snoopableBurst;
    logic        beginTransactionIn;
    logic        endTransactionIn;
    logic        dataValidIn;
    logic [1:0]  addressDataIn;
    logic [7:0]  burstSizeIn;

    int    checks = 0;
    int    errors = 0;
    out_t  expQ[$];
    string nameQ[$];
    vec_t  vecTable[21];

    sb_bus_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .busRequests       (busRequests),
        .busGrants         (busGrants),
        .busErrorOut       (busErrorOut),
        .endTransactionOut (endTransactionOut),
        .busIdle           (busIdle),
        .snoopableBurst    (snoopableBurst),
        .beginTransactionIn(beginTransactionIn),
        .endTransactionIn  (endTransactionIn),
        .dataValidIn       (dataValidIn),
        .addressDataIn     (addressDataIn),
        .burstSizeIn       (burstSizeIn)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mkVec(input logic [31:0] req, input logic b, input logic e,
                                   input logic d, input logic [1:0] a, input logic [7:0] bs,
                                   input logic [31:0] g, input logic idle, input logic sn,
                                   input logic er, input logic eo);
        vec_t v;
        v.req = req; v.beginT = b; v.endT = e; v.dv = d; v.addr = a; v.burst = bs;
        v.expGrants = g; v.expIdle = idle; v.expSnoop = sn; v.expErr = er; v.expEot = eo;
        return v;
    endfunction

    function automatic out_t sampleDut();
        out_t o;
        o.grants = busGrants; o.idle = busIdle; o.snoop = snoopableBurst;
        o.err = busErrorOut; o.eot = endTransactionOut;
        return o;
    endfunction

    task automatic compareOut(input string nm, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got grants=%h idle=%b snoop=%b err=%b eot=%b, expected grants=%h idle=%b snoop=%b err=%b eot=%b",
                     nm, act.grants, act.idle, act.snoop, act.err, act.eot,
                     exp.grants, exp.idle, exp.snoop, exp.err, exp.eot);
        end
    endtask

    task automatic checkOutput();
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got output with empty queue, expected a queued entry");
            return;
        end
        compareOut(nameQ.pop_front(), sampleDut(), expQ.pop_front());
    endtask

    // Drives one cycle of inputs just after an edge, queues the expectation,
    // then compares once the following edge has produced the outputs.
    task automatic applyStimulus(input vec_t v, input string nm);
        out_t e;
        busRequests        = v.req;
        beginTransactionIn = v.beginT;
        endTransactionIn   = v.endT;
        dataValidIn        = v.dv;
        addressDataIn      = v.addr;
        burstSizeIn        = v.burst;
        e.grants = v.expGrants; e.idle = v.expIdle; e.snoop = v.expSnoop;
        e.err = v.expErr; e.eot = v.expEot;
        expQ.push_back(e);
        nameQ.push_back(nm);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    task automatic silent(input logic [31:0] g, input logic idle, input logic sn,
                          input logic er, input string nm);
        applyStimulus(mkVec(32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, g, idle, sn, er, er), nm);
    endtask

    task automatic startBurst(input logic [1:0] a, input logic [7:0] bs, input logic expSn);
        applyStimulus(mkVec(32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0,
                            32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0), "wd_grant");
        applyStimulus(mkVec(32'h0, 1'b1, 1'b0, 1'b0, a, bs,
                            32'h0, 1'b0, expSn, 1'b0, 1'b0), "wd_begin");
    endtask

    initial begin
        out_t rstExp;
        rstExp = '{grants: 32'h0, idle: 1'b1, snoop: 1'b0, err: 1'b0, eot: 1'b0};

        reset = 1'b1;
        busRequests = '0; beginTransactionIn = 1'b0; endTransactionIn = 1'b0;
        dataValidIn = 1'b0; addressDataIn = 2'b00; burstSizeIn = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        compareOut("reset_state", sampleDut(), rstExp);
        reset = 1'b0;

        //                  req            beg   end   dv    addr   burst  grants         idle  snoop err   eot
        vecTable[0]  = mkVec(32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[1]  = mkVec(32'h8000_0000, 1'b1, 1'b0, 1'b0, 2'b01, 8'd3, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[2]  = mkVec(32'h0000_0000, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[3]  = mkVec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[4]  = mkVec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[5]  = mkVec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[6]  = mkVec(32'h0000_0000, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        vecTable[7]  = mkVec(32'h8000_0001, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[8]  = mkVec(32'h8000_0001, 1'b1, 1'b0, 1'b0, 2'b00, 8'd7, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        vecTable[9]  = mkVec(32'h8000_0001, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        vecTable[10] = mkVec(32'h0000_0001, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        vecTable[11] = mkVec(32'h0000_0001, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[12] = mkVec(32'h0000_0000, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[13] = mkVec(32'h0000_0000, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        vecTable[14] = mkVec(32'h0000_0100, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[15] = mkVec(32'h0000_0100, 1'b1, 1'b0, 1'b0, 2'b10, 8'd5, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[16] = mkVec(32'h0000_0000, 1'b0, 1'b1, 1'b1, 2'b00, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        vecTable[17] = mkVec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        vecTable[18] = mkVec(32'h0000_0006, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        vecTable[19] = mkVec(32'h0000_0000, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        vecTable[20] = mkVec(32'h0000_0000, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecTable[i], $sformatf("vec%0d", i));
        end

        // Grant held for 16 cycles without a begin strobe, then withdrawn with no error.
        applyStimulus(mkVec(32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0,
                            32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0), "gto_grant");
        for (int k = 1; k <= 16; k++) begin
            silent((k < 16) ? 32'h8000_0000 : 32'h0, (k == 16), 1'b0, 1'b0,
                   $sformatf("gto_cycle%0d", k));
        end
        silent(32'h0, 1'b1, 1'b0, 1'b0, "gto_after");

        // Silent slave on a snoopable burst: error and end pulse after 256 idle cycles.
        startBurst(2'b00, 8'd7, 1'b1);
        for (int j = 1; j <= 256; j++) begin
            silent(32'h0, (j == 256), (j < 256), (j == 256), $sformatf("wd_silent%0d", j));
        end
        silent(32'h0, 1'b1, 1'b0, 1'b0, "wd_pulse_end");

        // Data-valid on cycle 200 restarts the watchdog count.
        startBurst(2'b01, 8'd3, 1'b0);
        for (int j = 1; j <= 456; j++) begin
            applyStimulus(mkVec(32'h0, 1'b0, 1'b0, (j == 200), 2'b00, 8'd0,
                                32'h0, (j == 456), 1'b0, (j == 456), (j == 456)),
                          $sformatf("wd_restart%0d", j));
        end
        silent(32'h0, 1'b1, 1'b0, 1'b0, "wd_restart_end");

        // End strobe coinciding with the expiry cycle is a normal end.
        startBurst(2'b00, 8'd0, 1'b0);
        for (int j = 1; j <= 256; j++) begin
            applyStimulus(mkVec(32'h0, 1'b0, (j == 256), 1'b0, 2'b00, 8'd0,
                                32'h0, (j == 256), 1'b0, 1'b0, 1'b0),
                          $sformatf("wd_tie%0d", j));
        end
        silent(32'h0, 1'b1, 1'b0, 1'b0, "wd_tie_after");

        // Asynchronous reset while granted: grant must vanish between edges.
        applyStimulus(mkVec(32'h0000_0010, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0,
                            32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0), "rst_g_grant");
        #2;
        reset = 1'b1;
        busRequests = '0;
        #1;
        compareOut("rst_granted_async", sampleDut(), rstExp);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Asynchronous reset in a snoopable burst with another request pending.
        applyStimulus(mkVec(32'h8000_0002, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0,
                            32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0), "rst_b_grant");
        applyStimulus(mkVec(32'h8000_0002, 1'b1, 1'b0, 1'b0, 2'b00, 8'd7,
                            32'h0, 1'b0, 1'b1, 1'b0, 1'b0), "rst_b_begin");
        #2;
        reset = 1'b1;
        busRequests = '0;
        beginTransactionIn = 1'b0;
        #1;
        compareOut("rst_busy_async", sampleDut(), rstExp);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        silent(32'h0, 1'b1, 1'b0, 1'b0, "rst_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
